dmem_arbiter: RTL and testbench

Shares the byte-wide data memory between two 64-bit requesters: the CPU memory-access stage (port 0) and the memory loader/debug port (port 1). Each granted doubleword access is sequenced as eight byte beats, little-endian, to a single-port synchronous byte SRAM with one-cycle read latency. Sits between the memory-access stage and the 8192-byte data memory array.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_arbiter_if.sv | 35 +++
 rtl/dmem_rr_arb.sv | 39 +++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory arbiter slice: geometry of the
// byte-wide data memory, doubleword beat count and the sequencer state
// encoding used by dmem_arbiter.
package dmem_pkg;

    localparam int ADDR_W    = 13;
    localparam int BEATS     = 8;
    localparam int DATA_W    = 8 * BEATS;
    localparam int MEM_BYTES = 8192;
    localparam int CNT_W     = $clog2(BEATS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Requester-side bundle of the data-memory arbiter: two doubleword request
// ports (port 0 = memory-access stage, port 1 = loader/debug).
//   master : requester view (drives req/we/addr/wdata, receives ack/rdata)
//   slave  : arbiter view
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, rdata0, ack1, rdata1
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, rdata0, ack1, rdata1
    );

endinterface

// File: rtl/dmem_rr_arb.sv
// dmem_rr_arb
// Two-input round-robin grant. The grant is purely combinational from the
// current requests and the last-granted pointer; the pointer only moves when
// the owning sequencer reports a completed access.
//   clk, rst_n : clock, async active-low reset (pointer resets to port 1)
//   req0/req1  : live request lines
//   update     : pulse when an access completes
//   last_port  : port that completed, recorded on update
//   gnt_valid  : at least one requester present
//   gnt_port   : winning port
module dmem_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic last_port,
    output logic gnt_valid,
    output logic gnt_port
);

    logic last_q;

    // Pointer starts at 1 so port 0 wins the first contention after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= last_port;
        end
    end

    // A lone requester always wins; under contention the port not granted last wins.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_port  = (req0 && req1) ? ~last_q : req1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the byte-wide data SRAM between two 64-bit requesters. Each granted
// doubleword is sequenced as eight little-endian byte beats; reads need an
// extra DRAIN cycle because the SRAM returns data one cycle after the strobe.
//   clk, rst_n  : clock, async active-low reset
//   bus         : requester ports (slave modport)
//   busy        : high in every non-IDLE state
//   mem_en/we   : SRAM strobe / write enable
//   mem_addr    : SRAM byte address (wraps modulo memory size)
//   mem_wdata   : SRAM write byte
//   mem_rdata   : SRAM read byte, valid the cycle after a read strobe
module dmem_arbiter
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     bus,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic              cur_port;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [DATA_W-9:0] rbuf;
    logic              gnt_valid;
    logic              gnt_port;

    dmem_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (bus.req0),
        .req1      (bus.req1),
        .update    (state == ST_ACK),
        .last_port (cur_port),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: writes finish after the last beat, reads drain one more cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (gnt_valid) next_state = ST_BEAT;
            ST_BEAT:  if (cnt == CNT_W'(BEATS - 1)) next_state = cur_we ? ST_ACK : ST_DRAIN;
            ST_DRAIN: next_state = ST_ACK;
            ST_ACK:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state so reset forces them all low immediately.
    always_comb begin
        busy      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        bus.ack0  = 1'b0;
        bus.ack1  = 1'b0;
        case (state)
            ST_BEAT: begin
                busy      = 1'b1;
                mem_en    = 1'b1;
                mem_we    = cur_we;
                mem_addr  = cur_addr + ADDR_W'(cnt);
                mem_wdata = cur_wdata[{cnt, 3'b000} +: 8];
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            ST_ACK: begin
                busy     = 1'b1;
                bus.ack0 = ~cur_port;
                bus.ack1 = cur_port;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Request latch, beat counter and read assembly. Byte cnt-1 arrives during
    // beat cnt; byte 7 arrives in DRAIN, where the full doubleword is written to
    // the port's rdata so it is already valid in the ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            cur_port   <= 1'b0;
            cur_we     <= 1'b0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            rbuf       <= '0;
            bus.rdata0 <= '0;
            bus.rdata1 <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (gnt_valid) begin
                        cur_port  <= gnt_port;
                        cur_we    <= gnt_port ? bus.we1    : bus.we0;
                        cur_addr  <= gnt_port ? bus.addr1  : bus.addr0;
                        cur_wdata <= gnt_port ? bus.wdata1 : bus.wdata0;
                    end
                end
                ST_BEAT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!cur_we && cnt != '0) begin
                        rbuf[{cnt - CNT_W'(1), 3'b000} +: 8] <= mem_rdata;
                    end
                end
                ST_DRAIN: begin
                    if (cur_port) begin
                        bus.rdata1 <= {mem_rdata, rbuf};
                    end else begin
                        bus.rdata0 <= {mem_rdata, rbuf};
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural one-cycle-latency byte
// SRAM. A vector table covers single-port reads/writes, wrap and unaligned
// overlap; hand-written sequences cover contention, alternation, mid-transfer
// reset and a request arriving during a transfer.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte SRAM: read data appears the cycle after the strobe.
    logic [7:0] sram [0:MEM_BYTES-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    typedef struct {
        bit              port;
        bit              we;
        logic [12:0]     addr;
        logic [63:0]     data;
        logic [63:0]     expRd;
        int              expLat;
    } vec_t;

    vec_t        vecs [8];
    int          checks = 0;
    int          failures = 0;
    int          txLat;
    logic [63:0] txRdata;
    logic [12:0] beatAddr [16];
    logic [7:0]  beatData [16];
    int          beatCnt;
    bit          wrongAck;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drivePort(input bit port, input bit r, input bit w, input logic [12:0] a, input logic [63:0] d);
        if (port) begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    // One transaction on one port; cycle 0 is the IDLE cycle that samples req.
    task automatic applyStimulus(input bit port, input bit we, input logic [12:0] addr, input logic [63:0] wdata);
        @(posedge clk); #1;
        drivePort(port, 1'b1, we, addr, wdata);
        txLat = -1; beatCnt = 0; wrongAck = 1'b0; txRdata = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (mem_en) begin
                if (beatCnt < 16) begin
                    beatAddr[beatCnt] = mem_addr;
                    beatData[beatCnt] = mem_wdata;
                end
                beatCnt++;
            end
            if (port ? bus.ack0 : bus.ack1) wrongAck = 1'b1;
            if (port ? bus.ack1 : bus.ack0) begin
                txLat = n;
                txRdata = port ? bus.rdata1 : bus.rdata0;
                break;
            end
        end
        drivePort(port, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int a0, a1, k;
        int ackPort [4];
        int ackCyc [4];
        logic [63:0] rd1;
        bit sawAck;

        for (int i = 0; i < MEM_BYTES; i++) sram[i] = 8'h00;
        drivePort(1'b0, 1'b0, 1'b0, '0, '0);
        drivePort(1'b1, 1'b0, 1'b0, '0, '0);

        vecs[0] = '{1'b0, 1'b1, 13'h0040, 64'h0123456789ABCDEF, 64'h0, 9};
        vecs[1] = '{1'b0, 1'b0, 13'h0040, 64'h0, 64'h0123456789ABCDEF, 10};
        vecs[2] = '{1'b1, 1'b1, 13'd8190, 64'hFEDCBA9876543210, 64'h0, 9};
        vecs[3] = '{1'b1, 1'b0, 13'd8190, 64'h0, 64'hFEDCBA9876543210, 10};
        vecs[4] = '{1'b1, 1'b1, 13'h0100, 64'h1122334455667788, 64'h0, 9};
        vecs[5] = '{1'b0, 1'b0, 13'h0100, 64'h0, 64'h1122334455667788, 10};
        vecs[6] = '{1'b0, 1'b1, 13'h0103, 64'hAABBCCDDEEFF0011, 64'h0, 9};
        vecs[7] = '{1'b1, 1'b0, 13'h0100, 64'h0, 64'hDDEEFF0011667788, 10};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_ack", {bus.ack0, bus.ack1}, 0);
        checkOutput("rst_rdata0", bus.rdata0, 0);
        rst_n = 1'b1;

        // Contention straight out of reset: port 0 first
        @(posedge clk); #1;
        drivePort(1'b0, 1'b1, 1'b1, 13'h0200, 64'h0A0A0A0A0A0A0A0A);
        drivePort(1'b1, 1'b1, 1'b1, 13'h0208, 64'h0B0B0B0B0B0B0B0B);
        a0 = -1; a1 = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) checkOutput("cont_busy_c0", busy, 0);
            if (n == 9) checkOutput("cont_busy_c9", busy, 1);
            if (n == 10) checkOutput("cont_busy_c10", busy, 0);
            if (bus.ack0 && a0 < 0) begin a0 = n; drivePort(1'b0, 1'b0, 1'b0, '0, '0); end
            if (bus.ack1 && a1 < 0) begin a1 = n; drivePort(1'b1, 1'b0, 1'b0, '0, '0); end
            if (a0 >= 0 && a1 >= 0) break;
        end
        checkOutput("cont_ack0_cycle", 64'(a0), 9);
        checkOutput("cont_ack1_cycle", 64'(a1), 19);

        // Both held continuously: grants alternate 0,1,0,1
        @(posedge clk); #1;
        drivePort(1'b0, 1'b1, 1'b1, 13'h0300, 64'h1010101010101010);
        drivePort(1'b1, 1'b1, 1'b1, 13'h0308, 64'h2020202020202020);
        k = 0;
        for (int i = 0; i < 4; i++) begin ackPort[i] = -1; ackCyc[i] = -1; end
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                ackPort[k] = bus.ack1 ? 1 : 0;
                ackCyc[k] = n;
                k++;
                if (k == 4) begin
                    drivePort(1'b0, 1'b0, 1'b0, '0, '0);
                    drivePort(1'b1, 1'b0, 1'b0, '0, '0);
                    break;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("alt_port_%0d", i), 64'(ackPort[i]), 64'(i % 2));
            checkOutput($sformatf("alt_cycle_%0d", i), 64'(ackCyc[i]), 64'(9 + 10 * i));
        end

        // Vector table
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].data);
            checkOutput($sformatf("v%0d_latency", v), 64'(txLat), 64'(vecs[v].expLat));
            checkOutput($sformatf("v%0d_beats", v), 64'(beatCnt), 8);
            checkOutput($sformatf("v%0d_other_ack", v), wrongAck, 0);
            for (int i = 0; i < 8; i++) begin
                checkOutput($sformatf("v%0d_addr%0d", v, i), beatAddr[i], 13'(vecs[v].addr + 13'(i)));
                if (vecs[v].we)
                    checkOutput($sformatf("v%0d_wbyte%0d", v, i), beatData[i], vecs[v].data[8*i +: 8]);
            end
            if (!vecs[v].we)
                checkOutput($sformatf("v%0d_rdata", v), txRdata, vecs[v].expRd);
            if (v == 4)
                checkOutput("rdata1_hold", bus.rdata1, vecs[3].expRd);
        end

        // Reset during beat 4 of a port 0 write
        applyStimulus(1'b0, 1'b1, 13'h0400, 64'h8877665544332211);
        checkOutput("prerst_latency", 64'(txLat), 9);
        @(posedge clk); #1;
        drivePort(1'b0, 1'b1, 1'b1, 13'h0400, 64'hFFEEDDCCBBAA9988);
        for (int n = 0; n < 6; n++) @(negedge clk);
        checkOutput("beat4_addr", mem_addr, 13'h0404);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_mem_en", mem_en, 0);
        checkOutput("midrst_mem_we", mem_we, 0);
        checkOutput("midrst_mem_addr", mem_addr, 0);
        checkOutput("midrst_mem_wdata", mem_wdata, 0);
        checkOutput("midrst_rdata0", bus.rdata0, 0);
        checkOutput("midrst_rdata1", bus.rdata1, 0);
        drivePort(1'b0, 1'b0, 1'b0, '0, '0);
        sawAck = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) sawAck = 1'b1;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) sawAck = 1'b1;
        end
        checkOutput("midrst_no_ack", sawAck, 0);
        applyStimulus(1'b0, 1'b0, 13'h0400, 64'h0);
        checkOutput("midrst_readback", txRdata, 64'h88776655BBAA9988);

        // Port 1 read with req0 rising in cycle 3
        @(posedge clk); #1;
        drivePort(1'b1, 1'b1, 1'b0, 13'h0040, 64'h0);
        a0 = -1; a1 = -1; rd1 = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 3) drivePort(1'b0, 1'b1, 1'b1, 13'h0500, 64'h0F0E0D0C0B0A0908);
            if (bus.ack1 && a1 < 0) begin a1 = n; rd1 = bus.rdata1; drivePort(1'b1, 1'b0, 1'b0, '0, '0); end
            if (bus.ack0 && a0 < 0) begin a0 = n; drivePort(1'b0, 1'b0, 1'b0, '0, '0); end
            if (a0 >= 0 && a1 >= 0) break;
        end
        checkOutput("late_ack1_cycle", 64'(a1), 10);
        checkOutput("late_rdata1", rd1, 64'h0123456789ABCDEF);
        checkOutput("late_ack0_cycle", 64'(a0), 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
